// File: rtl/mem_width_bridge.sv
// Splits each 32-bit core access into two 16-bit RAM transactions (low half first),
// stalling the core until both halves finish or time out.
module mem_width_bridge #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        cpu_read_i,
   input  logic        cpu_write_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic [31:0] cpu_rdata_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        mem_go_o,
   output logic        mem_we_o,
   output logic [25:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_done_i
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LO_ISSUE = 3'd1,
      LO_WAIT  = 3'd2,
      HI_ISSUE = 3'd3,
      HI_WAIT  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t      state_q;
   logic [23:0] hw_addr_q;
   logic [15:0] wdata_hi_q;
   logic        wr_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        go_q;
   logic        we_q;
   logic [25:0] maddr_q;
   logic [15:0] mwdata_q;

   logic        req;
   logic        tmo;
   logic [15:0] half_rdata;
   logic        unused_addr_bits;

   assign req              = cpu_read_i | cpu_write_i;
   assign cnt_d            = cnt_q + 16'd1;
   assign tmo              = (cnt_q == 16'(TIMEOUT - 1));
   // A late halfword is treated as complete but contributes zeros.
   assign half_rdata       = mem_done_i ? mem_rdata_i : 16'h0000;
   assign unused_addr_bits = ^{cpu_addr_i[31:26], cpu_addr_i[1:0]};

   assign stall_o     = req && (state_q != DONE);
   assign cpu_rdata_o = rdata_q;
   assign err_o       = err_q;
   assign mem_go_o    = go_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = maddr_q;
   assign mem_wdata_o = mwdata_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         hw_addr_q  <= '0;
         wdata_hi_q <= '0;
         wr_q       <= 1'b0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         go_q       <= 1'b0;
         we_q       <= 1'b0;
         maddr_q    <= '0;
         mwdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  hw_addr_q  <= cpu_addr_i[25:2];
                  wdata_hi_q <= cpu_wdata_i[31:16];
                  wr_q       <= cpu_write_i;
                  go_q       <= 1'b1;
                  we_q       <= cpu_write_i;
                  maddr_q    <= {1'b0, cpu_addr_i[25:2], 1'b0};
                  mwdata_q   <= cpu_wdata_i[15:0];
                  state_q    <= LO_ISSUE;
               end
            end
            LO_ISSUE: begin
               go_q    <= 1'b0;
               cnt_q   <= '0;
               state_q <= LO_WAIT;
            end
            LO_WAIT: begin
               if (mem_done_i || tmo) begin
                  if (!wr_q) rdata_q[15:0] <= half_rdata;
                  if (!mem_done_i) err_q <= 1'b1;
                  go_q     <= 1'b1;
                  maddr_q  <= {1'b0, hw_addr_q, 1'b1};
                  mwdata_q <= wdata_hi_q;
                  state_q  <= HI_ISSUE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            HI_ISSUE: begin
               go_q    <= 1'b0;
               cnt_q   <= '0;
               state_q <= HI_WAIT;
            end
            HI_WAIT: begin
               if (mem_done_i || tmo) begin
                  if (!wr_q) rdata_q[31:16] <= half_rdata;
                  if (!mem_done_i) err_q <= 1'b1;
                  we_q    <= 1'b0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_width_bridge.sv
// Randomised bench for mem_width_bridge: a transaction-level timing model predicts every
// output on every cycle, plus literal checks for the directed scenarios.
module tb_mem_width_bridge;

   localparam int TO = 8;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        cpu_read_i, cpu_write_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i;
   logic [31:0] cpu_rdata_o;
   logic        stall_o, err_o, mem_go_o, mem_we_o;
   logic [25:0] mem_addr_o;
   logic [15:0] mem_wdata_o, mem_rdata_i;
   logic        mem_done_i;

   mem_width_bridge #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_rdata_o(cpu_rdata_o), .stall_o(stall_o), .err_o(err_o),
      .mem_go_o(mem_go_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_done_i(mem_done_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // expected outputs for the current cycle
   logic        exp_valid = 1'b0;
   logic        exp_stall, exp_go, exp_we, exp_err;
   logic [25:0] exp_addr;
   logic [15:0] exp_wdata;
   logic [31:0] exp_rdata;

   // architectural state carried between accesses
   logic [25:0] m_addr;
   logic [15:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_err;

   int          last_stalls, last_gos;
   logic [25:0] first_go_addr;
   logic [15:0] first_go_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk_i) begin
      if (exp_valid) begin
         chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
         chk("go", {31'b0, mem_go_o}, {31'b0, exp_go});
         chk("we", {31'b0, mem_we_o}, {31'b0, exp_we});
         chk("addr", {6'b0, mem_addr_o}, {6'b0, exp_addr});
         chk("wdata", {16'b0, mem_wdata_o}, {16'b0, exp_wdata});
         chk("rdata", cpu_rdata_o, exp_rdata);
         chk("err", {31'b0, err_o}, {31'b0, exp_err});
      end
   end

   task automatic idle(input int n, input bit spur);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
         cpu_read_i  = 1'b0;
         cpu_write_i = 1'b0;
         cpu_addr_i  = $urandom;
         cpu_wdata_i = $urandom;
         mem_done_i  = spur ? 1'($urandom % 2) : 1'b0;
         mem_rdata_i = 16'($urandom);
         exp_valid = 1'b1;
         exp_stall = 1'b0; exp_go = 1'b0; exp_we = 1'b0;
         exp_addr  = m_addr; exp_wdata = m_wdata;
         exp_rdata = m_rdata; exp_err = m_err;
      end
   endtask

   // l1/l2: memory latency in cycles after each go; anything above TO never completes
   task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wd, input int l1, input int l2,
                         input logic [15:0] h1, input logic [15:0] h2, input bit spur);
      bit          to1, to2;
      int          w1, w2, h, d;
      logic [25:0] lo_a, hi_a;
      logic [15:0] lo_v, hi_v;
      logic [31:0] rd_now;
      to1 = (l1 > TO); to2 = (l2 > TO);
      w1 = to1 ? TO : l1; w2 = to2 ? TO : l2;
      h = 2 + w1;
      d = h + w2 + 1;
      lo_a = {1'b0, addr[25:2], 1'b0};
      hi_a = {1'b0, addr[25:2], 1'b1};
      lo_v = to1 ? 16'h0000 : h1;
      hi_v = to2 ? 16'h0000 : h2;
      rd_now = m_rdata;
      last_stalls = 0; last_gos = 0;
      for (int r = 0; r <= d; r++) begin
         @(posedge clk_i); #1;
         cpu_read_i = rd; cpu_write_i = wr;
         cpu_addr_i = addr; cpu_wdata_i = wd;
         if (!to1 && r == 1 + l1) begin
            mem_done_i = 1'b1; mem_rdata_i = h1;
         end else if (!to2 && r == h + l2) begin
            mem_done_i = 1'b1; mem_rdata_i = h2;
         end else begin
            mem_done_i  = (spur && (r == 0 || r == 1 || r == h || r == d)) ? 1'($urandom % 2) : 1'b0;
            mem_rdata_i = 16'($urandom);
         end
         exp_valid = 1'b1;
         exp_stall = (r < d);
         exp_go    = (r == 1) || (r == h);
         exp_we    = wr && (r >= 1) && (r < d);
         exp_addr  = (r == 0) ? m_addr  : ((r < h) ? lo_a : hi_a);
         exp_wdata = (r == 0) ? m_wdata : ((r < h) ? wd[15:0] : wd[31:16]);
         if (!wr && r >= h) rd_now[15:0]  = lo_v;
         if (!wr && r >= d) rd_now[31:16] = hi_v;
         exp_rdata = rd_now;
         exp_err   = m_err | (to1 && r >= h) | (to2 && r >= d);
         @(negedge clk_i);
         if (stall_o === 1'b1) last_stalls++;
         if (mem_go_o === 1'b1) begin
            if (last_gos == 0) begin
               first_go_addr  = mem_addr_o;
               first_go_wdata = mem_wdata_o;
            end
            last_gos++;
         end
      end
      m_addr = hi_a; m_wdata = wd[31:16]; m_rdata = rd_now; m_err = exp_err;
      chk("go_count", last_gos, 2);
      chk("stall_cycles", last_stalls, d);
      $display("access wr=%0b rd=%0b addr=%h wdata=%h lat=%0d/%0d rdata=%h err=%0b stalls=%0d",
               wr, rd, addr, wd, l1, l2, cpu_rdata_o, err_o, last_stalls);
   endtask

   task automatic random_accesses(input int n);
      for (int i = 0; i < n; i++) begin
         logic wr, rd;
         int   l1, l2;
         wr = 1'($urandom % 2);
         rd = wr ? 1'($urandom % 2) : 1'b1;
         l1 = ($urandom % 8 == 0) ? $urandom_range(9, 12) : $urandom_range(1, 5);
         l2 = ($urandom % 8 == 0) ? $urandom_range(9, 12) : $urandom_range(1, 5);
         access(wr, rd, $urandom, $urandom, l1, l2, 16'($urandom), 16'($urandom), 1'b1);
         idle($urandom_range(0, 2), 1'b1);
      end
   endtask

   initial begin
      rstn_i = 1'b0;
      cpu_read_i = 1'b0; cpu_write_i = 1'b0;
      cpu_addr_i = '0; cpu_wdata_i = '0;
      mem_rdata_i = '0; mem_done_i = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_rdata", cpu_rdata_o, 32'h0);
      chk("rst_stall", {31'b0, stall_o}, 32'h0);
      chk("rst_go", {31'b0, mem_go_o}, 32'h0);
      chk("rst_addr", {6'b0, mem_addr_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      rstn_i = 1'b1;
      idle(2, 1'b1);

      // write 0xCAFEBEEF to 0x10, single-cycle memory
      access(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_BEEF, 1, 1, 16'h0, 16'h0, 1'b0);
      chk("wr_lo_addr", {6'b0, first_go_addr}, 32'h8);
      chk("wr_lo_data", {16'b0, first_go_wdata}, 32'hBEEF);
      chk("wr_hi_addr", {6'b0, mem_addr_o}, 32'h9);
      chk("wr_hi_data", {16'b0, mem_wdata_o}, 32'hCAFE);
      chk("wr_stalls", last_stalls, 5);
      idle(1, 1'b1);

      // read 0x10 with 3-cycle latency
      access(1'b0, 1'b1, 32'h0000_0010, 32'h0, 3, 3, 16'h1234, 16'hABCD, 1'b1);
      chk("rd_data", cpu_rdata_o, 32'hABCD_1234);
      chk("rd_stalls", last_stalls, 9);

      // read+write together, back-to-back: the write wins, read data untouched
      access(1'b1, 1'b1, 32'h0000_0004, 32'h5555_AAAA, 1, 2, 16'h1111, 16'h2222, 1'b1);
      chk("rw_rdata_kept", cpu_rdata_o, 32'hABCD_1234);
      chk("rw_lo_addr", {6'b0, first_go_addr}, 32'h2);
      chk("rw_lo_data", {16'b0, first_go_wdata}, 32'hAAAA);
      idle(1, 1'b0);

      // done on the very last wait cycle still counts as done
      access(1'b0, 1'b1, 32'h0000_0020, 32'h0, TO, TO, 16'h1111, 16'h2222, 1'b0);
      chk("edge_data", cpu_rdata_o, 32'h2222_1111);
      chk("edge_err", {31'b0, err_o}, 32'h0);

      // low half never answers
      access(1'b0, 1'b1, 32'h0000_0030, 32'h0, 100, 1, 16'hDEAD, 16'h00FF, 1'b0);
      chk("tmo_data", cpu_rdata_o, 32'h00FF_0000);
      chk("tmo_err", {31'b0, err_o}, 32'h1);
      chk("tmo_stalls", last_stalls, 12);
      access(1'b1, 1'b0, 32'h0000_0040, 32'h1357_9BDF, 1, 1, 16'h0, 16'h0, 1'b0);
      chk("err_sticky", {31'b0, err_o}, 32'h1);
      idle(1, 1'b1);

      random_accesses(40);

      // reset while in HI_WAIT
      for (int r = 0; r <= 4; r++) begin
         @(posedge clk_i); #1;
         exp_valid   = 1'b0;
         cpu_read_i  = 1'b1; cpu_write_i = 1'b0;
         cpu_addr_i  = 32'h0000_0100; cpu_wdata_i = '0;
         mem_done_i  = (r == 2);
         mem_rdata_i = 16'h7777;
      end
      #2 rstn_i = 1'b0;
      cpu_read_i = 1'b0;
      #1;
      chk("arst_rdata", cpu_rdata_o, 32'h0);
      chk("arst_stall", {31'b0, stall_o}, 32'h0);
      chk("arst_err", {31'b0, err_o}, 32'h0);
      chk("arst_go", {31'b0, mem_go_o}, 32'h0);
      chk("arst_we", {31'b0, mem_we_o}, 32'h0);
      chk("arst_addr", {6'b0, mem_addr_o}, 32'h0);
      chk("arst_wdata", {16'b0, mem_wdata_o}, 32'h0);
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
      idle(6, 1'b1);

      random_accesses(5);
      idle(2, 1'b0);

      exp_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_width_bridge.md
# mem_width_bridge

Bridges the 32-bit single-cycle MIPS core bus to the 16-bit cellular RAM controller. Each 32-bit read or write is split into two sequential halfword transactions, low half first. The core is stalled until both halves complete. The block sits between `mips_sc_top` and `memory_interface`, and drives the core's `stall_i`.

## Interface
- `TIMEOUT`, default 64: cycles to wait for `mem_done_i` per halfword before aborting. Legal range 2..65535.
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  asynchronous reset, active-low.
- `cpu_read_i`  in  1  core read request; held by the core while stalled.
- `cpu_write_i`  in  1  core write request; held by the core while stalled.
- `cpu_addr_i`  in  32  byte address; bits [1:0] ignored.
- `cpu_wdata_i`  in  32  write data.
- `cpu_rdata_o`  out  32  read data, registered.
- `stall_o`  out  1  stall to core.
- `err_o`  out  1  sticky timeout flag.
- `mem_go_o`  out  1  one-cycle start pulse to the RAM controller.
- `mem_we_o`  out  1  write enable for the current halfword.
- `mem_addr_o`  out  26  halfword address.
- `mem_wdata_o`  out  16  halfword write data.
- `mem_rdata_i`  in  16  halfword read data.
- `mem_done_i`  in  1  one-cycle pulse: current halfword complete, and for reads `mem_rdata_i` is valid.

## Operation
- States: IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, DONE.
- IDLE
  - On `cpu_read_i | cpu_write_i`, latch address, write data and op, then go to LO_ISSUE.
  - Write wins if both requests are high. The op is a write and no read data is captured.
- LO_ISSUE
  - `mem_go_o`=1 and `mem_addr_o`={1'b0, addr[25:2], 1'b0}.
  - `mem_wdata_o`=wdata[15:0].
  - Next state: LO_WAIT.
- LO_WAIT
  - On `mem_done_i`: for a read, capture `mem_rdata_i` into `cpu_rdata_o[15:0]`; go to HI_ISSUE.
- HI_ISSUE
  - Same as LO_ISSUE, with address LSB=1 and `mem_wdata_o`=wdata[31:16].
  - Next state: HI_WAIT.
- HI_WAIT
  - On `mem_done_i`: for a read, capture into `cpu_rdata_o[31:16]`; go to DONE.
- DONE
  - Lasts one cycle, then returns to IDLE.
- `stall_o` = (`cpu_read_i` | `cpu_write_i`) & (state != DONE). It is combinational, so the core is stalled from the cycle the request appears.
- `mem_we_o` = latched op in ISSUE and WAIT states, 0 otherwise.
- `mem_addr_o` and `mem_wdata_o` hold their values through the WAIT states.
- `mem_done_i` is ignored outside the WAIT states.
- Timeout
  - A 16-bit counter clears on entry to each WAIT state and increments each WAIT cycle.
  - At count == TIMEOUT-1 without `mem_done_i`, `err_o` is set.
  - The state advances as if done; for reads, that half is captured as 16'h0000.
  - `err_o` clears only on reset.
  - A `mem_done_i` arriving in the same cycle as the timeout counts as done, and `err_o` is not set.
- Reset values: state IDLE, `cpu_rdata_o`=0, `err_o`=0, `mem_go_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, counter 0.
- A reset mid-transaction aborts immediately; no further `mem_go_o` is issued.
- `cpu_rdata_o` holds its last value until the next read captures new data.

## Timing
- Earliest `mem_done_i` is the cycle after the matching `mem_go_o`.
- With minimum memory latency, a request appearing in cycle 0 proceeds as follows:
  - Cycle 1: LO_ISSUE.
  - Cycle 2: LO_WAIT with done.
  - Cycle 3: HI_ISSUE.
  - Cycle 4: HI_WAIT with done.
  - Cycle 5: DONE, `stall_o`=0 and `cpu_rdata_o` valid.
- Result: 5 stalled cycles. Each extra memory wait cycle adds one.
- Back-to-back requests: a new request in the cycle after DONE is accepted in IDLE with no bubble beyond that cycle.
- Exactly two `mem_go_o` pulses per access, never overlapping a WAIT state.

## Test plan
- Write: addr 0x0000_0010, data 0xCAFE_BEEF, done 1 cycle after each go.
  - Go pulses at cycles 1 and 3.
  - Addresses 0x8 (data 0xBEEF) and 0x9 (data 0xCAFE), `mem_we_o`=1.
  - `stall_o` falls at cycle 5.
- Read: addr 0x10, memory returns 0x1234 then 0xABCD with 3-cycle latency.
  - `cpu_rdata_o`=0xABCD_1234 in DONE.
  - 9 stalled cycles.
- Simultaneous read and write at addr 0x4, wdata 0x5555_AAAA.
  - Writes are issued.
  - `cpu_rdata_o` is unchanged from its previous value.
- Timeout: TIMEOUT=8, no `mem_done_i` on the low half.
  - After 8 LO_WAIT cycles: `err_o`=1 and HI_ISSUE follows.
  - With a normal high half 0x00FF, read result is 0x00FF_0000.
  - `err_o` stays 1 on later good accesses.
- Reset asserted during HI_WAIT: all outputs reach their reset values asynchronously.
  - After release with no request: `stall_o`=0 and no `mem_go_o`.
- Spurious `mem_done_i` in IDLE and ISSUE states: no state change and no data capture.
